// File: rtl/uart_pkg.sv
// Shared UART register offsets, status bit positions and rx FSM encoding.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;

  localparam int ST_AVAIL = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_FERR  = 3;
  localparam int ST_PERR  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Peripheral slave bus: one-cycle read/write strobes, registered read data.
// Shared by the led, uart, bram and spram peripherals.
interface uart_rx_if;

  logic [4:0] addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [7:0] wr_data;

  modport master (
    output addr, rd_en, wr_en, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  addr, rd_en, wr_en, wr_data,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO, power-of-two depth, naturally wrapping pointers.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Bus-mapped UART receiver: 8N1 deserialiser, receive FIFO, DATA/STATUS regs.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity-error status bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  uart_rx_if.slave    bus,
  input  logic        rx,
  output logic        rx_avail
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = S_PARITY;
`else
  localparam rx_state_t AFTER_DATA = S_STOP;
`endif

  rx_state_t     state;
  rx_state_t     nxt;
  logic          sync1;
  logic          rxs;
  logic          rxs_d;
  logic          fall;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic ld_half;
  logic ld_full;
  logic shift;
  logic push_req;
  logic ferr_set;
  logic par_smp;

  logic          ovr;
  logic          ferr;
  logic          perr;
  logic          ovr_set;
  logic          full;
  logic          empty;
  logic [AW:0]   fcnt;
  logic [7:0]    head;
  logic          pop;
  logic          sel_data;
  logic          sel_status;
  logic          w1c;
  logic [7:0]    status;
  logic [7:0]    rd_mux;
  logic [7:0]    rdq;
  logic          rvq;
  logic          unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // only a 1->0 transition starts a frame, so a stuck-low line stays idle
  assign fall = rxs_d && !rxs;
  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (fall) nxt = S_START;
      S_START:  if (tick) nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_idx == 3'd7) nxt = AFTER_DATA;
      S_PARITY: if (tick) nxt = S_STOP;
      S_STOP:   if (tick) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ld_half  = 1'b0;
    ld_full  = 1'b0;
    shift    = 1'b0;
    push_req = 1'b0;
    ferr_set = 1'b0;
    par_smp  = 1'b0;
    unique case (state)
      S_IDLE:   ld_half = fall;
      S_START:  ld_full = tick && !rxs;
      S_DATA: begin
        ld_full = tick;
        shift   = tick;
      end
      S_PARITY: begin
        ld_full = tick;
        par_smp = tick;
      end
      S_STOP: begin
        push_req = tick && rxs;
        ferr_set = tick && !rxs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (ld_half)                       cnt <= HALF;
      else if (ld_full)                  cnt <= FULL;
      else if (state != S_IDLE && !tick) cnt <= cnt - 1'b1;
      if (ld_half)    bit_idx <= '0;
      else if (shift) bit_idx <= bit_idx + 1'b1;
      if (shift) shreg <= {rxs, shreg[7:1]};
    end
  end

  assign sel_data   = (bus.addr[2:0] == REG_DATA);
  assign sel_status = (bus.addr[2:0] == REG_STATUS);
  assign pop        = bus.rd_en && sel_data && !empty;
  assign w1c        = bus.wr_en && sel_status;
  assign ovr_set    = push_req && full && !pop;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (shreg),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fcnt)
  );

  // a set event in the same cycle as its W1C wins
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~(w1c & bus.wr_data[ST_OVR]));
      ferr <= ferr_set | (ferr & ~(w1c & bus.wr_data[ST_FERR]));
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_set;
  assign perr_set = par_smp && (even_par(shreg) != rxs);

  always_ff @(posedge clk) begin
    if (rst) perr <= 1'b0;
    else     perr <= perr_set | (perr & ~(w1c & bus.wr_data[ST_PERR]));
  end
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    status           = '0;
    status[ST_AVAIL] = !empty;
    status[ST_FULL]  = full;
    status[ST_OVR]   = ovr;
    status[ST_FERR]  = ferr;
    status[ST_PERR]  = perr;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_data:   rd_mux = empty ? 8'h00 : head;
      sel_status: rd_mux = status;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdq <= '0;
      rvq <= 1'b0;
    end else begin
      rvq <= bus.rd_en;
      if (bus.rd_en) rdq <= rd_mux;
    end
  end

  assign bus.rd_data  = rdq;
  assign bus.rd_valid = rvq;
  assign rx_avail     = (fcnt != '0);

  assign unused = ^{bus.addr[4:3], bus.wr_data[7:4],
                    bus.wr_data[1:0], par_smp};

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios, register table,
// randomized frames against a queue-based reference model.
module tb_uart_rx;

  localparam int DIV = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int LAT = (NB - 2) * DIV + 18;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic rx_avail;

  uart_rx_if bif ();

  uart_rx #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif),
    .rx       (rx),
    .rx_avail (rx_avail)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    bif.addr  = a;
    bif.rd_en = 1'b1;
    @(negedge clk);
    bif.rd_en = 1'b0;
    chk("rd_valid", {31'b0, bif.rd_valid}, 32'd1);
    d = bif.rd_data;
    @(negedge clk);
    chk("rd_valid_pulse", {31'b0, bif.rd_valid}, 32'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bif.addr    = a;
    bif.wr_data = d;
    bif.wr_en   = 1'b1;
    @(negedge clk);
    bif.wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a,
                        input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    chk(name, {24'b0, d}, {24'b0, exp});
  endtask

  // rise = negedge index (start bit at 0) where rx_avail first goes high
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_bit, input int rst_at,
                            output int rise);
    logic [10:0] bits;
    logic        prev;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = par_bit;
    bits[10] = stop_bit;
`else
    bits[9]  = stop_bit;
    bits[10] = par_bit;
`endif
    rise = -1;
    prev = rx_avail;
    for (int i = 0; i < (NB + 1) * DIV; i++) begin
      @(negedge clk);
      if (rx_avail && !prev && rise < 0) rise = i;
      prev = rx_avail;
      if (i == rst_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rd_data", {24'b0, bif.rd_data}, 32'h0);
        chk("rst_rd_valid", {31'b0, bif.rd_valid}, 32'h0);
        chk("rst_rx_avail", {31'b0, rx_avail}, 32'h0);
        return;
      end
      rx = (i / DIV < NB) ? bits[i / DIV] : 1'b1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          rise;
    logic [7:0]  d;
    logic [7:0]  q[$];
    logic        mo;
    logic        mf;
    logic [7:0]  exp;
    logic        good;
    int          op;

    rst         = 1'b1;
    rx          = 1'b1;
    bif.addr    = '0;
    bif.rd_en   = 1'b0;
    bif.wr_en   = 1'b0;
    bif.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd_data", {24'b0, bif.rd_data}, 32'h0);
    chk("reset_rd_valid", {31'b0, bif.rd_valid}, 32'h0);
    chk("reset_rx_avail", {31'b0, rx_avail}, 32'h0);
    rst = 1'b0;
    rd_chk("reset_status", 5'd1, 8'h00);

    // single frame and latency
    send_frame(8'hA5, 1'b1, ^8'hA5, -1, rise);
    chk("latency", rise, LAT);
    rd_chk("t1_status", 5'd1, 8'h01);
    rd_chk("t1_data", 5'd0, 8'hA5);
    rd_chk("t1_status2", 5'd1, 8'h00);

    // fill and overrun, then register table
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, ^8'(b), -1, rise);
    end
    tbl.push_back('{1'b0, 5'd1,  8'h00, 8'h07});
    tbl.push_back('{1'b0, 5'd0,  8'h00, 8'h01});
    tbl.push_back('{1'b0, 5'd0,  8'h00, 8'h02});
    tbl.push_back('{1'b0, 5'd9,  8'h00, 8'h05});
    tbl.push_back('{1'b0, 5'd0,  8'h00, 8'h03});
    tbl.push_back('{1'b0, 5'd0,  8'h00, 8'h04});
    tbl.push_back('{1'b0, 5'd0,  8'h00, 8'h00});
    tbl.push_back('{1'b0, 5'd1,  8'h00, 8'h04});
    tbl.push_back('{1'b1, 5'd2,  8'hFF, 8'h00});
    tbl.push_back('{1'b1, 5'd0,  8'h55, 8'h00});
    tbl.push_back('{1'b0, 5'd1,  8'h00, 8'h04});
    tbl.push_back('{1'b0, 5'd2,  8'h00, 8'h00});
    tbl.push_back('{1'b0, 5'd7,  8'h00, 8'h00});
    tbl.push_back('{1'b1, 5'd1,  8'hF3, 8'h00});
    tbl.push_back('{1'b0, 5'd1,  8'h00, 8'h04});
    tbl.push_back('{1'b1, 5'd1,  8'h04, 8'h00});
    tbl.push_back('{1'b0, 5'd1,  8'h00, 8'h00});
    tbl.push_back('{1'b0, 5'd0,  8'h00, 8'h00});
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // framing error
    send_frame(8'h3C, 1'b0, ^8'h3C, -1, rise);
    rd_chk("t3_ferr", 5'd1, 8'h08);
    chk("t3_avail", {31'b0, rx_avail}, 32'h0);
    wr(5'd1, 8'h08);
    rd_chk("t3_clear", 5'd1, 8'h00);

    // glitch, then stuck-low line
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("t4_glitch", 5'd1, 8'h00);
    chk("t4_glitch_avail", {31'b0, rx_avail}, 32'h0);
    rx = 1'b0;
    repeat (150) @(negedge clk);
    rd_chk("t4_low_ferr", 5'd1, 8'h08);
    wr(5'd1, 8'h08);
    repeat (100) @(negedge clk);
    rd_chk("t4_no_retrigger", 5'd1, 8'h00);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("t4_release", 5'd1, 8'h00);

    // reset in the middle of data bit 4
    send_frame(8'h11, 1'b1, ^8'h11, -1, rise);
    rd_chk("t5_pre", 5'd1, 8'h01);
    send_frame(8'hC3, 1'b1, ^8'hC3, 55, rise);
    repeat (20) @(negedge clk);
    rd_chk("t5_after_rst", 5'd1, 8'h00);
    send_frame(8'h5A, 1'b1, ^8'h5A, -1, rise);
    rd_chk("t5_data", 5'd0, 8'h5A);
    rd_chk("t5_status", 5'd1, 8'h00);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1, rise);
    rd_chk("t6_perr", 5'd1, 8'h11);
    rd_chk("t6_data", 5'd0, 8'h07);
    wr(5'd1, 8'h10);
    rd_chk("t6_clear", 5'd1, 8'h00);
    send_frame(8'h07, 1'b1, 1'b1, -1, rise);
    rd_chk("t6_ok", 5'd1, 8'h01);
    rd_chk("t6_data2", 5'd0, 8'h07);
`else
    send_frame(8'h07, 1'b1, 1'b0, -1, rise);
    wr(5'd1, 8'h10);
    rd_chk("t6_no_perr", 5'd1, 8'h01);
    rd_chk("t6_data", 5'd0, 8'h07);
`endif

    // randomized traffic against a queue model
    mo = 1'b0;
    mf = 1'b0;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 4);
      if (op <= 1) begin
        d    = 8'($urandom);
        good = ($urandom_range(0, 7) != 0);
        send_frame(d, good, ^d, -1, rise);
        if (!good)            mf = 1'b1;
        else if (q.size() < 4) q.push_back(d);
        else                  mo = 1'b1;
      end else if (op == 2) begin
        exp = (q.size() != 0) ? q.pop_front() : 8'h00;
        rd_chk($sformatf("rnd%0d_data", n), 5'd0, exp);
      end else if (op == 3) begin
        exp = {3'b000, 1'b0, mf, mo, q.size() == 4, q.size() != 0};
        rd_chk($sformatf("rnd%0d_status", n), 5'd1, exp);
      end else begin
        d = 8'($urandom);
        wr(5'd1, d);
        if (d[2]) mo = 1'b0;
        if (d[3]) mf = 1'b0;
      end
      chk($sformatf("rnd%0d_avail", n), {31'b0, rx_avail},
          {31'b0, q.size() != 0});
    end
    exp = {3'b000, 1'b0, mf, mo, q.size() == 4, q.size() != 0};
    rd_chk("rnd_final_status", 5'd1, exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
